// File: rtl/stereo_match_ssd_if.sv
// rtl/stereo_match_ssd_if.sv - pixel-set input and cost output bundle for stereo_match_ssd
interface stereo_match_ssd_if #(
  parameter int PIXEL_WIDTH = 4,
  parameter int NUM_DISP    = 9,
  parameter int OUT_WIDTH   = 9
);
  logic [PIXEL_WIDTH-1:0] left_pixel_in;
  logic [PIXEL_WIDTH-1:0] right_pixel_in [NUM_DISP-1:0];
  logic                   valid_in;
  logic [OUT_WIDTH-1:0]   ssd_out;
  logic                   valid_out;

  modport master (
    output left_pixel_in, right_pixel_in, valid_in,
    input  ssd_out, valid_out
  );

  modport slave (
    input  left_pixel_in, right_pixel_in, valid_in,
    output ssd_out, valid_out
  );
endinterface

// File: rtl/stereo_match_ssd.sv
// rtl/stereo_match_ssd.sv - pipelined minimum squared-difference cost over all disparities
module stereo_match_ssd #(
  parameter int PIXEL_WIDTH = 4,
  parameter int NUM_DISP    = 9,
  parameter int OUT_WIDTH   = 9
) (
  input logic              clk_in,
  input logic              rst_in,
  stereo_match_ssd_if.slave bus
);
  localparam int DW  = PIXEL_WIDTH + 1;
  localparam int SW  = 2 * PIXEL_WIDTH;
  localparam int N4  = (NUM_DISP + 1) / 2;
  localparam int N5A = (N4 + 1) / 2;
  localparam int N5  = (N5A + 1) / 2;

  logic [PIXEL_WIDTH-1:0] s1_left;
  logic [PIXEL_WIDTH-1:0] s1_right [NUM_DISP];
  logic signed [DW-1:0]   s2_diff  [NUM_DISP];
  logic [SW-1:0]          s3_sq    [NUM_DISP];
  logic [SW-1:0]          s4_min   [N4];
  logic [SW-1:0]          s5_min   [N5];
  logic [SW-1:0]          s6_min;
  logic [5:0]             vld;

  logic signed [DW-1:0]   diff_c  [NUM_DISP];
  logic [SW-1:0]          sq_c    [NUM_DISP];
  logic [SW-1:0]          lvl4_c  [N4];
  logic [SW-1:0]          lvl5a_c [N5A];
  logic [SW-1:0]          lvl5_c  [N5];
  logic [SW-1:0]          min6_c;
  logic [OUT_WIDTH-1:0]   ssd_c;

  function automatic logic [SW-1:0] min2(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return (b < a) ? b : a;
  endfunction

  always_comb begin
    for (int d = 0; d < NUM_DISP; d++)
      diff_c[d] = $signed({1'b0, s1_left}) - $signed({1'b0, s1_right[d]});
  end

  // |diff| always fits in PIXEL_WIDTH bits, so squaring the magnitude avoids a signed multiplier
  always_comb begin
    logic [PIXEL_WIDTH-1:0] mag;
    mag = '0;
    for (int d = 0; d < NUM_DISP; d++) begin
      mag      = PIXEL_WIDTH'(s2_diff[d][DW-1] ? -s2_diff[d] : s2_diff[d]);
      sq_c[d]  = SW'(mag) * SW'(mag);
    end
  end

  for (genvar i = 0; i < N4; i++) begin : g_lvl4
    if (2 * i + 1 < NUM_DISP) begin : g_pair
      assign lvl4_c[i] = min2(s3_sq[2*i], s3_sq[2*i+1]);
    end else begin : g_pass
      assign lvl4_c[i] = s3_sq[2*i];
    end
  end

  for (genvar i = 0; i < N5A; i++) begin : g_lvl5a
    if (2 * i + 1 < N4) begin : g_pair
      assign lvl5a_c[i] = min2(s4_min[2*i], s4_min[2*i+1]);
    end else begin : g_pass
      assign lvl5a_c[i] = s4_min[2*i];
    end
  end

  for (genvar i = 0; i < N5; i++) begin : g_lvl5
    if (2 * i + 1 < N5A) begin : g_pair
      assign lvl5_c[i] = min2(lvl5a_c[2*i], lvl5a_c[2*i+1]);
    end else begin : g_pass
      assign lvl5_c[i] = lvl5a_c[2*i];
    end
  end

  always_comb begin
    min6_c = s5_min[0];
    for (int i = 1; i < N5; i++)
      min6_c = min2(min6_c, s5_min[i]);
  end

  if (SW > OUT_WIDTH) begin : g_sat
    assign ssd_c = (s6_min > SW'({OUT_WIDTH{1'b1}})) ? {OUT_WIDTH{1'b1}} : s6_min[OUT_WIDTH-1:0];
  end else begin : g_ext
    assign ssd_c = OUT_WIDTH'(s6_min);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld           <= '0;
      s1_left       <= '0;
      s6_min        <= '0;
      bus.ssd_out   <= '0;
      bus.valid_out <= 1'b0;
      for (int d = 0; d < NUM_DISP; d++) begin
        s1_right[d] <= '0;
        s2_diff[d]  <= '0;
        s3_sq[d]    <= '0;
      end
      for (int i = 0; i < N4; i++) s4_min[i] <= '0;
      for (int i = 0; i < N5; i++) s5_min[i] <= '0;
    end else begin
      vld     <= {vld[4:0], bus.valid_in};
      s1_left <= bus.left_pixel_in;
      for (int d = 0; d < NUM_DISP; d++) begin
        s1_right[d] <= bus.right_pixel_in[d];
        s2_diff[d]  <= diff_c[d];
        s3_sq[d]    <= sq_c[d];
      end
      for (int i = 0; i < N4; i++) s4_min[i] <= lvl4_c[i];
      for (int i = 0; i < N5; i++) s5_min[i] <= lvl5_c[i];
      s6_min        <= min6_c;
      bus.valid_out <= vld[5];
      // cost output holds its last result through gaps
      if (vld[5]) bus.ssd_out <= ssd_c;
    end
  end
endmodule

// File: tb/tb_stereo_match_ssd.sv
// tb/tb_stereo_match_ssd.sv - directed-vector self-checking bench for stereo_match_ssd
module tb_stereo_match_ssd;
  logic clk_in = 1'b0;
  logic rst_in;

  stereo_match_ssd_if #(.PIXEL_WIDTH(4), .NUM_DISP(9), .OUT_WIDTH(9)) bus ();

  stereo_match_ssd #(.PIXEL_WIDTH(4), .NUM_DISP(9), .OUT_WIDTH(9)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic       hv [512];
  logic [8:0] he [512];
  logic [8:0] last_exp;

  logic [3:0]  vl [12];
  logic [35:0] vr [12];
  logic [8:0]  ve [12];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 512; i++) begin
      hv[i] = 1'b0;
      he[i] = '0;
    end
    last_exp = '0;
  endtask

  // Inputs applied at negedge j are sampled on the next posedge; their result is visible at negedge j+7.
  task automatic step(input logic v, input logic [3:0] l, input logic [35:0] r, input logic [8:0] e);
    logic exp_v;
    @(negedge clk_in);
    exp_v = (cyc >= 7) ? hv[cyc-7] : 1'b0;
    check_eq("valid_out", 32'(bus.valid_out), 32'(exp_v));
    if (exp_v) last_exp = he[cyc-7];
    check_eq("ssd_out", 32'(bus.ssd_out), 32'(last_exp));
    bus.valid_in      = v;
    bus.left_pixel_in = l;
    for (int d = 0; d < 9; d++) bus.right_pixel_in[d] = r[4*d +: 4];
    hv[cyc] = v && rst_in;
    he[cyc] = e;
    cyc++;
  endtask

  initial begin
    vl[0]  = 4'd4;  vr[0]  = 36'h626262626; ve[0]  = 9'd4;
    vl[1]  = 4'd9;  vr[1]  = 36'hF0F90F0F0; ve[1]  = 9'd0;
    vl[2]  = 4'd0;  vr[2]  = 36'hFFFFFFFFF; ve[2]  = 9'd225;
    vl[3]  = 4'd7;  vr[3]  = 36'h876543210; ve[3]  = 9'd0;
    vl[4]  = 4'd15; vr[4]  = 36'hEEEEEEEEF; ve[4]  = 9'd0;
    vl[5]  = 4'd15; vr[5]  = 36'hDAAAAAAAA; ve[5]  = 9'd4;
    vl[6]  = 4'd3;  vr[6]  = 36'h9D1A6F80C; ve[6]  = 9'd4;
    vl[7]  = 4'd10; vr[7]  = 36'hDEF543210; ve[7]  = 9'd9;
    vl[8]  = 4'd0;  vr[8]  = 36'h4CBA98765; ve[8]  = 9'd16;
    vl[9]  = 4'd15; vr[9]  = 36'h000000000; ve[9]  = 9'd225;
    vl[10] = 4'd8;  vr[10] = 36'hEF7654321; ve[10] = 9'd1;
    vl[11] = 4'd2;  vr[11] = 36'hF7C0E6D9B; ve[11] = 9'd4;

    clear_model();
    bus.valid_in      = 1'b0;
    bus.left_pixel_in = '0;
    for (int d = 0; d < 9; d++) bus.right_pixel_in[d] = '0;
    rst_in = 1'b1;
    #1 rst_in = 1'b0;

    // reset held with valid toggling; last applied valid is 0 so nothing slips past release
    for (int i = 0; i < 8; i++)
      step((i < 7) ? logic'(i % 2) : 1'b0, vl[i], vr[i], ve[i]);
    rst_in = 1'b1;

    for (int i = 0; i < 10; i++) step(1'b1, vl[0], vr[0], ve[0]);
    for (int i = 0; i < 8; i++)  step(1'b0, vl[9], vr[9], 9'd0);

    for (int i = 1; i <= 5; i++) step(1'b1, vl[i], vr[i], ve[i]);
    for (int i = 0; i < 8; i++)  step(1'b0, vl[2], vr[2], 9'd0);

    begin
      logic gp [7];
      int k;
      gp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      k = 0;
      for (int rep = 0; rep < 2; rep++) begin
        for (int i = 0; i < 7; i++) begin
          if (gp[i]) begin
            step(1'b1, vl[6 + k % 6], vr[6 + k % 6], ve[6 + k % 6]);
            k++;
          end else begin
            step(1'b0, vl[2], vr[2], 9'd0);
          end
        end
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, vl[9], vr[9], 9'd0);

    for (int i = 0; i < 10; i++) step(1'b1, vl[7], vr[7], ve[7]);
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    check_eq("async_valid_drop", 32'(bus.valid_out), 32'd0);
    check_eq("async_ssd_drop", 32'(bus.ssd_out), 32'd0);
    clear_model();
    @(posedge clk_in);
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    rst_in = 1'b1;

    for (int i = 0; i < 9; i++) step(1'b0, vl[9], vr[9], 9'd0);
    step(1'b1, vl[11], vr[11], ve[11]);
    for (int i = 0; i < 9; i++) step(1'b0, vl[9], vr[9], 9'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/stereo_match_ssd.md
Name: stereo_match_ssd

Overview:
- Per-pixel stereo matching cost unit.
- Each cycle it takes one left-image pixel and NUM_DISP right-image candidate pixels, one per disparity.
- It computes the squared difference for every candidate in parallel and outputs the minimum cost over all disparities.
- It sits between the pixel-alignment buffers and the disparity-selection / depth-map logic. It is fully pipelined and accepts one new pixel set per clock.

Parameters:
- PIXEL_WIDTH, 4, bit width of each pixel.
- NUM_DISP, 9, number of candidate disparities (right pixels) compared per left pixel.
- OUT_WIDTH, 9, width of the cost output.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- left_pixel_in  input  PIXEL_WIDTH  left-image pixel, unsigned.
- right_pixel_in  input  NUM_DISP x PIXEL_WIDTH  unpacked array [NUM_DISP-1:0]; element d is the right pixel at disparity d, unsigned.
- valid_in  input  1  qualifies left_pixel_in and right_pixel_in in this cycle.
- ssd_out  output  OUT_WIDTH  minimum squared difference across all disparities, unsigned.
- valid_out  output  1  ssd_out holds a valid result this cycle.

Behaviour:
- Reset: while rst_in=0, all pipeline valid bits, valid_out and ssd_out are forced to 0 immediately (asynchronous). Data pipeline registers are also cleared to 0.
- Reset mid-operation: all in-flight results are discarded and none emerge after release. The first valid_out follows the first valid_in sampled after release, with full latency.
- Fixed latency of 6 cycles. valid_in=1 sampled at edge N gives valid_out=1 with its ssd_out during the cycle after edge N+6. valid_out is valid_in delayed 6 cycles; there is no backpressure.
- S1: register left and all right pixels plus valid.
- S2: per disparity d, compute the signed difference left - right[d] in PIXEL_WIDTH+1 bits.
- S3: square each difference, unsigned, 2*PIXEL_WIDTH bits. This is the squared-difference multiplier stage; the order of operands does not change the result.
- S4: first minimum-tree level, 9 values to 5 (four pairwise minimums, element 8 passed through).
- S5: two tree levels, 5 to 3 to 2.
- S6: final minimum, 2 to 1, registered into ssd_out.
- Comparisons are unsigned. Ties return the equal value, so the cost is unaffected.
- Width rule: squared cost is zero-extended to OUT_WIDTH. If a parameter set makes a square exceed OUT_WIDTH, saturate to all ones.
- Pipeline registers advance every cycle. Data stages may load regardless of valid, but ssd_out only changes when the S6 valid bit is 1. ssd_out holds its last value while valid_out=0.
- Inputs are masked to PIXEL_WIDTH bits; upper bits of wider driven values are ignored.
- Back-to-back valid_in produces back-to-back valid_out in the same order. Gaps in valid_in reproduce as identical gaps in valid_out.

Test Plan:
- Reset: hold rst_in=0 with valid_in=1 toggling -> valid_out=0 and ssd_out=0 throughout. Assert rst_in=0 asynchronously mid-cycle -> outputs drop before the next edge.
- Alternating candidates: left=4, right={6,2,6,2,6,2,6,2,6}, valid_in=1 continuously after release -> valid_out rises 6 cycles after the first sampled valid, ssd_out=4 every cycle.
- Exact match: left=9, right[5]=9, others 0 or 15 -> ssd_out=0. Then left=0, right all 15 -> ssd_out=225.
- Minimum position: left=7, right[d]=d for d=0..8 -> ssd_out=0 (d=7). Left=15, right all 14 except right[0]=15 -> ssd_out=0. Left=15, right[8]=13, others 10 -> ssd_out=4.
- Streaming and gaps: random pixels with valid_in pattern 1,1,0,1,0,0,1 -> identical valid_out pattern delayed 6 cycles. Each ssd_out equals the reference minimum of (l-r[d])^2.
- Reset mid-stream: 3 valids in flight, pulse rst_in low for 1 cycle -> none of them appear. The next valid after release appears at latency 6.
